// File: rtl/serial_rx_5b.sv
// Oversampling serial frame receiver: start bit, DATA_W data bits LSB first, stop bit.
// Recovers each word, pulses valid on success or frame_err on a low stop bit.
module serial_rx_5b #(
   parameter int DATA_W = 5,
   parameter int OVS    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              rx,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              frame_err,
   output logic              mesgul
);

   localparam int TW = $clog2(OVS);
   localparam int BW = $clog2(DATA_W + 1);

   localparam logic [TW-1:0] TICK_MID = TW'(OVS / 2 - 1);
   localparam logic [TW-1:0] TICK_END = TW'(OVS - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t              r_state;
   logic                r_sync1;
   logic                r_sync2;
   logic [TW-1:0]       r_tick;
   logic [BW-1:0]       r_bit;
   logic [DATA_W-1:0]   r_shift;
   logic [DATA_W-1:0]   r_data;
   logic                r_valid;
   logic                r_ferr;
   logic                r_mesgul;
   logic                w_rs;

   assign w_rs      = r_sync2;
   assign data      = r_data;
   assign valid     = r_valid;
   assign frame_err = r_ferr;
   assign mesgul    = r_mesgul;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_state  <= S_IDLE;
         r_tick   <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_ferr   <= 1'b0;
         r_mesgul <= 1'b0;
      end else begin
         // Synchronizer runs every clk; only the FSM is gated by en.
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         if (en) begin
            case (r_state)
               S_IDLE: begin
                  if (!w_rs) begin
                     r_state  <= S_START;
                     r_tick   <= '0;
                     r_mesgul <= 1'b1;
                  end
               end
               S_START: begin
                  if (r_tick == TICK_MID) begin
                     r_tick <= '0;
                     if (!w_rs) begin
                        r_state <= S_DATA;
                        r_bit   <= '0;
                     end else begin
                        r_state  <= S_IDLE;
                        r_mesgul <= 1'b0;
                     end
                  end else begin
                     r_tick <= r_tick + 1'b1;
                  end
               end
               S_DATA: begin
                  if (r_tick == TICK_END) begin
                     r_tick  <= '0;
                     r_shift <= {w_rs, r_shift[DATA_W-1:1]};
                     r_bit   <= r_bit + 1'b1;
                     if (r_bit == BIT_LAST) begin
                        r_state <= S_STOP;
                     end
                  end else begin
                     r_tick <= r_tick + 1'b1;
                  end
               end
               S_STOP: begin
                  if (r_tick == TICK_END) begin
                     r_tick <= '0;
                     if (w_rs) begin
                        r_data   <= r_shift;
                        r_valid  <= 1'b1;
                        r_state  <= S_IDLE;
                        r_mesgul <= 1'b0;
                     end else begin
                        r_ferr  <= 1'b1;
                        r_state <= S_WAIT_IDLE;
                     end
                  end else begin
                     r_tick <= r_tick + 1'b1;
                  end
               end
               S_WAIT_IDLE: begin
                  // A held-low line (break) keeps us here; only a high line re-arms.
                  if (w_rs) begin
                     r_state  <= S_IDLE;
                     r_mesgul <= 1'b0;
                  end
               end
               default: begin
                  r_state  <= S_IDLE;
                  r_mesgul <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
